// File: rtl/snake_collide_if.sv
// snake_collide_if: segment positions in, food/score/status out for the collision block.
interface snake_collide_if;
    logic step;
    logic [8:0] snake_x0, snake_x1, snake_x2, snake_x3, snake_x4;
    logic [8:0] snake_y0, snake_y1, snake_y2, snake_y3, snake_y4;
    logic grow;
    logic [8:0] food_x, food_y;
    logic [7:0] score;
    logic game_over;
    logic busy;
    modport master (
        output step, snake_x0, snake_x1, snake_x2, snake_x3, snake_x4,
        output snake_y0, snake_y1, snake_y2, snake_y3, snake_y4,
        input grow, food_x, food_y, score, game_over, busy
    );
    modport slave (
        input step, snake_x0, snake_x1, snake_x2, snake_x3, snake_x4,
        input snake_y0, snake_y1, snake_y2, snake_y3, snake_y4,
        output grow, food_x, food_y, score, game_over, busy
    );
endinterface

// File: rtl/snake_collide.sv
// snake_collide: per-step wall/self collision check, food detection and LFSR food placement.
module snake_collide #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239
) (
    input logic clk,
    input logic rst,
    snake_collide_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, WALL = 3'd1, SCAN = 3'd2, FOOD = 3'd3, OVER = 3'd4;
    localparam logic [8:0] XM = 9'(X_MAX), XW = 9'(X_MAX + 1);
    localparam logic [8:0] YM = 9'(Y_MAX), YW = 9'(Y_MAX + 1);
    logic [2:0] state, len, i;
    logic [8:0] sx [5];
    logic [8:0] sy [5];
    logic [15:0] lfsr;
    logic [8:0] food_x, food_y, nfx, nfy, ly;
    logic [7:0] score;
    logic grow, hit, eat, wall;
    assign ly = {1'b0, lfsr[15:8]};
    // fold out-of-range LFSR values back into the play field by one wrap
    assign nfx = lfsr[8:0] > XM ? lfsr[8:0] - XW : lfsr[8:0];
    assign nfy = ly > YM ? ly - YW : ly;
    assign wall = sx[0] > XM || sy[0] > YM;
    assign hit = sx[0] == sx[i] && sy[0] == sy[i];
    assign eat = sx[0] == food_x && sy[0] == food_y;
    assign bus.grow = grow;
    assign bus.food_x = food_x;
    assign bus.food_y = food_y;
    assign bus.score = score;
    assign bus.game_over = state == OVER;
    assign bus.busy = state == WALL || state == SCAN || state == FOOD;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            len <= 3'd1;
            i <= 3'd1;
            grow <= 1'b0;
            score <= 8'd0;
            food_x <= 9'd160;
            food_y <= 9'd120;
            lfsr <= 16'hACE1;
            for (int k = 0; k < 5; k++) begin
                sx[k] <= 9'd0;
                sy[k] <= 9'd0;
            end
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            grow <= 1'b0;
            case (state)
                IDLE: if (bus.step) begin
                    sx <= '{bus.snake_x0, bus.snake_x1, bus.snake_x2, bus.snake_x3, bus.snake_x4};
                    sy <= '{bus.snake_y0, bus.snake_y1, bus.snake_y2, bus.snake_y3, bus.snake_y4};
                    state <= WALL;
                end
                WALL: begin
                    i <= 3'd1;
                    state <= wall ? OVER : len == 3'd1 ? FOOD : SCAN;
                end
                SCAN: begin
                    state <= hit ? OVER : i == len - 3'd1 ? FOOD : SCAN;
                    i <= hit || i == len - 3'd1 ? i : i + 3'd1;
                end
                FOOD: begin
                    if (eat) begin
                        grow <= 1'b1;
                        score <= score == 8'hFF ? score : score + 8'd1;
                        len <= len == 3'd5 ? len : len + 3'd1;
                        food_x <= nfx;
                        food_y <= nfy;
                    end
                    state <= IDLE;
                end
                default: state <= OVER;
            endcase
        end
    end
endmodule
